// File: rtl/redmule_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | redmule_port_arbiter_if : load/store requests and shared-port handshake |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface redmule_port_arbiter_if #(
    parameter int NumSrc = 4
);
    localparam int SelW = $clog2(NumSrc + 1);

    logic              z_priority_i;
    logic [NumSrc-1:0] src_req_i;
    logic              sink_req_i;
    logic              port_ready_i;
    logic              port_valid_o;
    logic [SelW-1:0]   sel_o;
    logic [NumSrc-1:0] src_gnt_o;
    logic              sink_gnt_o;
    logic              starve_o;

    modport slave (
        input  z_priority_i, src_req_i, sink_req_i, port_ready_i,
        output port_valid_o, sel_o, src_gnt_o, sink_gnt_o, starve_o
    );

    modport master (
        output z_priority_i, src_req_i, sink_req_i, port_ready_i,
        input  port_valid_o, sel_o, src_gnt_o, sink_gnt_o, starve_o
    );
endinterface
`default_nettype wire

// File: rtl/redmule_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | redmule_port_arbiter : load round-robin / store class arbiter with anti-starvation |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module redmule_port_arbiter #(
    parameter int NumSrc   = 4,
    parameter int MaxStall = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    redmule_port_arbiter_if.slave  bus
);
    localparam int SelW = $clog2(NumSrc + 1);
    localparam int IdxW = (NumSrc > 1) ? $clog2(NumSrc) : 1;
    localparam int CntW = $clog2(MaxStall + 1);
    localparam logic [CntW-1:0] STALL_MAX = CntW'(MaxStall);
    localparam logic [SelW-1:0] SEL_STORE = SelW'(NumSrc);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_e;

    state_e          state, state_nxt;
    logic [SelW-1:0] sel, sel_nxt;
    logic [IdxW-1:0] rr_ptr, rr_ptr_nxt;
    logic [CntW-1:0] stall_cnt, stall_cnt_nxt;
    logic            zprio_prev;

    logic            valid, grant, gnt_load, gnt_store;
    logic            load_req, pref_req, other_req, pick_store, found;
    logic [IdxW-1:0] pick_idx;

    always_comb begin
        valid      = (state != IDLE);
        grant      = valid && bus.port_ready_i;
        gnt_load   = grant && (state == LOAD);
        gnt_store  = grant && (state == STORE);
        load_req   = |bus.src_req_i;
        pref_req   = bus.z_priority_i ? bus.sink_req_i : load_req;
        other_req  = bus.z_priority_i ? load_req : bus.sink_req_i;

        rr_ptr_nxt = rr_ptr;
        if (gnt_load) begin
            rr_ptr_nxt = IdxW'((int'(sel) + 1) % NumSrc);
        end

        stall_cnt_nxt = stall_cnt;
        if (bus.z_priority_i != zprio_prev) begin
            stall_cnt_nxt = '0;
        end else if (grant) begin
            if ((gnt_store == bus.z_priority_i) && other_req) begin
                stall_cnt_nxt = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
            end else begin
                stall_cnt_nxt = '0;
            end
        end

        // Decide with the post-edge pointer and counter so back-to-back
        // decisions see the effect of the grant happening on this edge.
        if ((stall_cnt_nxt == STALL_MAX) && other_req) begin
            pick_store = !bus.z_priority_i;
        end else if (pref_req) begin
            pick_store = bus.z_priority_i;
        end else begin
            pick_store = !bus.z_priority_i;
        end

        found    = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NumSrc; i++) begin
            automatic int idx = (int'(rr_ptr_nxt) + i) % NumSrc;
            if (!found && bus.src_req_i[idx]) begin
                found    = 1'b1;
                pick_idx = IdxW'(idx);
            end
        end

        state_nxt = state;
        sel_nxt   = sel;
        if (!valid || grant) begin
            if (load_req || bus.sink_req_i) begin
                state_nxt = pick_store ? STORE : LOAD;
                sel_nxt   = pick_store ? SEL_STORE : SelW'(pick_idx);
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            sel        <= '0;
            rr_ptr     <= '0;
            stall_cnt  <= '0;
            zprio_prev <= 1'b0;
        end else if (clear_i) begin
            state      <= IDLE;
            sel        <= '0;
            rr_ptr     <= '0;
            stall_cnt  <= '0;
            zprio_prev <= bus.z_priority_i;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            rr_ptr     <= rr_ptr_nxt;
            stall_cnt  <= stall_cnt_nxt;
            zprio_prev <= bus.z_priority_i;
        end
    end

    // Clear masks outputs in its own cycle so a locked transfer never grants.
    always_comb begin
        bus.port_valid_o = valid && !clear_i;
        bus.sel_o        = clear_i ? '0 : sel;
        bus.sink_gnt_o   = gnt_store && !clear_i;
        bus.starve_o     = (stall_cnt == STALL_MAX) && !clear_i;
        for (int i = 0; i < NumSrc; i++) begin
            bus.src_gnt_o[i] = gnt_load && !clear_i && (sel == SelW'(i));
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_redmule_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_redmule_port_arbiter : directed checks of arbitration, lock, starvation, reset |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_redmule_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    redmule_port_arbiter_if #(.NumSrc(4)) bus ();

    redmule_port_arbiter #(.NumSrc(4), .MaxStall(16)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [5];
    logic [3:0] lock_pat [5];

    initial begin
        rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        lock_pat = '{4'b1011, 4'b0001, 4'b1111, 4'b0000, 4'b1000};

        rst_n = 1'b0; clear = 1'b0;
        bus.z_priority_i = 1'b0; bus.src_req_i = '0; bus.sink_req_i = 1'b0; bus.port_ready_i = 1'b0;
        #12;
        check("rst_valid", 32'(bus.port_valid_o), 32'd0);
        check("rst_sel", 32'(bus.sel_o), 32'd0);
        check("rst_src_gnt", 32'(bus.src_gnt_o), 32'd0);
        check("rst_sink_gnt", 32'(bus.sink_gnt_o), 32'd0);
        check("rst_starve", 32'(bus.starve_o), 32'd0);
        tick();
        rst_n = 1'b1;

        // Round-robin sweep, one-cycle decision latency
        bus.src_req_i = 4'b1111; bus.port_ready_i = 1'b1;
        #1;
        check("rr_latency", 32'(bus.port_valid_o), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("rr_gnt", 32'(bus.src_gnt_o), 32'(rr_exp[i]));
            if (i == 4) bus.src_req_i = '0;
            tick();
        end
        check("rr_idle", 32'(bus.port_valid_o), 32'd0);

        // Lock while not ready (pointer is now 1)
        bus.src_req_i = 4'b0100; bus.port_ready_i = 1'b0;
        tick();
        check("lock_sel", 32'(bus.sel_o), 32'd2);
        for (int i = 0; i < 5; i++) begin
            bus.src_req_i = lock_pat[i];
            #1;
            check("lock_hold", 32'({bus.sel_o, bus.src_gnt_o}), 32'({3'd2, 4'b0000}));
            tick();
        end
        bus.port_ready_i = 1'b1; bus.src_req_i = '0;
        #1;
        check("lock_gnt", 32'(bus.src_gnt_o), 32'b0100);
        tick();
        check("lock_idle", 32'(bus.port_valid_o), 32'd0);

        // Synchronous clear drops a locked transfer (pointer is now 3)
        bus.src_req_i = 4'b0001; bus.port_ready_i = 1'b0;
        tick();
        check("clr_sel", 32'(bus.sel_o), 32'd0);
        clear = 1'b1; bus.port_ready_i = 1'b1;
        #1;
        check("clr_outputs", 32'({bus.port_valid_o, bus.src_gnt_o, bus.sink_gnt_o}), 32'd0);
        tick();
        clear = 1'b0; bus.src_req_i = '0; bus.port_ready_i = 1'b0;
        #1;
        check("clr_idle", 32'(bus.port_valid_o), 32'd0);

        // Store served when loads are idle; late load waits for the store grant
        bus.sink_req_i = 1'b1;
        tick();
        check("st_sel", 32'(bus.sel_o), 32'd4);
        bus.src_req_i = 4'b0010;
        tick();
        tick();
        check("st_lock", 32'({bus.sel_o, bus.sink_gnt_o, bus.src_gnt_o}), 32'({3'd4, 1'b0, 4'b0000}));
        bus.port_ready_i = 1'b1; bus.sink_req_i = 1'b0;
        #1;
        check("st_gnt", 32'({bus.sink_gnt_o, bus.src_gnt_o}), 32'({1'b1, 4'b0000}));
        tick();
        check("st_then_load", 32'({bus.sel_o, bus.src_gnt_o}), 32'({3'd1, 4'b0010}));
        bus.src_req_i = '0;
        tick();
        check("st_idle", 32'(bus.port_valid_o), 32'd0);

        // Store priority: 16 store grants, forced load, stores resume
        bus.z_priority_i = 1'b1; bus.sink_req_i = 1'b1; bus.src_req_i = 4'b0001;
        tick();
        for (int k = 0; k < 16; k++) begin
            check("stv_store", 32'({bus.starve_o, bus.sink_gnt_o, bus.src_gnt_o}), 32'({1'b0, 1'b1, 4'b0000}));
            tick();
        end
        check("stv_forced", 32'({bus.starve_o, bus.sink_gnt_o, bus.src_gnt_o}), 32'({1'b1, 1'b0, 4'b0001}));
        tick();
        check("stv_resume", 32'({bus.starve_o, bus.sink_gnt_o, bus.src_gnt_o}), 32'({1'b0, 1'b1, 4'b0000}));
        bus.sink_req_i = 1'b0; bus.src_req_i = '0;
        tick();
        check("stv_idle", 32'(bus.port_valid_o), 32'd0);

        // Asynchronous reset mid-transfer (pointer is now 1)
        bus.z_priority_i = 1'b0; bus.src_req_i = 4'b1000; bus.port_ready_i = 1'b0;
        tick();
        check("ar_sel", 32'(bus.sel_o), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_outputs", 32'({bus.port_valid_o, bus.sel_o, bus.src_gnt_o, bus.sink_gnt_o, bus.starve_o}), 32'd0);
        bus.port_ready_i = 1'b1;
        tick();
        check("ar_no_gnt", 32'(bus.src_gnt_o), 32'd0);
        rst_n = 1'b1; bus.src_req_i = 4'b1111;
        #1;
        check("ar_idle", 32'(bus.port_valid_o), 32'd0);
        tick();
        check("ar_restart", 32'({bus.sel_o, bus.src_gnt_o}), 32'({3'd0, 4'b0001}));
        bus.src_req_i = '0; bus.port_ready_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
